// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : one prefetch FIFO entry {pc, inst}
//   INST_BYTES    : byte stride between sequential fetches
//   NOP_INST      : canonical RISC-V nop (addi x0, x0, 0)
//   align_pc      : force a fetch address onto a word boundary
//   sat_add       : 32-bit saturating add used by the optional FETCH_STATS_EN counters
package fetch_unit_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/clear, registered storage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write one entry (ignored when full unless popping too)
//   pop                 : remove head (ignored when empty)
//   clear               : drop all entries; dominates push/pop
//   rd_data             : current head entry (registered storage)
//   count, full, empty  : occupancy status
// DEPTH need not be a power of two; pointers wrap explicitly.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction-fetch front end.
//   clk, rst                        : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       : word fetch requests to instruction memory
//   imem_rsp_valid/data             : in-order responses, never back-pressured
//   inst_valid/ready, inst_pc/data  : buffered {pc, inst} toward decode
//   redirect, redirect_pc           : one-cycle flush-and-refetch pulse
//   halt                            : level, stops issuing new requests
//   busy                            : work in flight or buffered
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed
// saturating counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed,
`endif
  output logic        busy
);

  localparam int unsigned PF_DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PF_CNT_W = $clog2(PF_DEPTH + 1);
  localparam int unsigned OS_CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned OCC_W    = ((PF_CNT_W > OS_CNT_W) ? PF_CNT_W : OS_CNT_W) + 1;

  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [OS_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t        pf_wr;
  fetch_entry_t        pf_head;
  logic [PF_CNT_W-1:0] pf_count;
  logic                pf_full;
  logic                pf_empty;
  logic                pf_push;
  logic                pf_pop;

  logic [31:0]         tag_head;
  logic [OS_CNT_W-1:0] tag_count;
  logic                tag_full;
  logic                tag_empty;

  logic [OCC_W-1:0]    occupancy;
  logic                req_fire;
  logic                rsp_drop;
  logic                unused_pf_full;

  // Outstanding requests are exactly the tag FIFO occupancy, so no separate counter.
  assign occupancy = OCC_W'(pf_count) + OCC_W'(tag_count);

  // Reserving FIFO space for every in-flight request keeps the prefetch FIFO
  // from ever overflowing, since responses cannot be back-pressured.
  assign imem_req_valid = rst && !halt && !redirect && !tag_full
                          && (occupancy < OCC_W'(PF_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (redirect || (drop_cnt_q != '0));
  assign pf_push  = imem_rsp_valid && !rsp_drop;
  assign pf_pop   = inst_valid && inst_ready;
  assign pf_wr    = '{pc: tag_head, inst: imem_rsp_data};

  assign inst_valid = !pf_empty;
  assign inst_pc    = pf_empty ? '0 : pf_head.pc;
  assign inst_data  = pf_empty ? '0 : pf_head.inst;
  assign busy       = !tag_empty || !pf_empty;

  assign unused_pf_full = pf_full;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
    end

    // On redirect every request still in flight after this cycle's response
    // belongs to the wrong path; recomputing from the live count avoids
    // double counting when redirects arrive back to back.
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      drop_cnt_d = tag_count - OS_CNT_W'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - OS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (PF_DEPTH)
  ) u_prefetch_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (pf_push),
    .push_data (pf_wr),
    .pop       (pf_pop),
    .clear     (redirect),
    .rd_data   (pf_head),
    .count     (pf_count),
    .full      (pf_full),
    .empty     (pf_empty)
  );

  // Tag FIFO pops on every response, including discarded ones, so it always
  // tracks the in-flight PCs in memory order.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .clear     (1'b0),
    .rd_data   (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;
  logic [31:0] flush_add;

  always_comb begin
    flush_add = 32'(rsp_drop);
    if (redirect) begin
      flush_add = flush_add + 32'(pf_count) - 32'(pf_pop);
    end
    stat_fetched_d = sat_add(stat_fetched_q, 32'(pf_pop));
    stat_flushed_d = sat_add(stat_flushed_q, flush_add);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned PF_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        busy;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .DEPTH_LOG2 (2),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
`ifdef FETCH_STATS_EN
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Reference model: transaction queues, epoch-tagged in-flight requests.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; int unsigned epoch; } fl_t;
  typedef struct { int unsigned due; logic [31:0] data; } mr_t;

  ent_t        exp_q[$];
  fl_t         inflight[$];
  mr_t         mem_q[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  logic [31:0] m_pc;
  int unsigned m_fetched = 0;
  int unsigned m_flushed = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic        use_nop = 1'b1;
  int          first_req_cyc = -1;
  int          first_val_cyc = -1;

  logic        last_req_valid;
  logic [31:0] last_req_addr;
  logic        last_busy;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic exp_rv, acc, pop, rsp;
    fl_t  f;
    mr_t  md;
    int unsigned due;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = !halt && !redirect && (exp_q.size() + inflight.size() < PF_DEPTH)
             && (inflight.size() < MAX_OUTST);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("inst_pc", inst_pc, exp_q[0].pc);
      chk("inst_data", inst_data, exp_q[0].inst);
    end
    chk("busy", 32'(busy), 32'(exp_q.size() != 0 || inflight.size() != 0));
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, m_fetched);
    chk("stat_flushed", stat_flushed, m_flushed);
`endif
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    last_busy      = busy;
    acc = exp_rv && imem_req_ready;
    pop = (exp_q.size() != 0) && inst_ready;
    rsp = imem_rsp_valid;
    if (acc && first_req_cyc < 0) first_req_cyc = int'(cyc);
    if (exp_q.size() != 0 && first_val_cyc < 0) first_val_cyc = int'(cyc);
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      m_fetched++;
    end
    if (rsp) begin
      f  = inflight.pop_front();
      md = mem_q.pop_front();
      if (redirect || f.epoch != epoch) m_flushed++;
      else exp_q.push_back('{pc: f.pc, inst: md.data});
    end
    if (redirect) begin
      m_flushed += exp_q.size();
      exp_q.delete();
      epoch++;
      m_pc = redirect_pc & ~32'd3;
    end
    if (acc) begin
      inflight.push_back('{pc: m_pc, epoch: epoch});
      due = cyc + $urandom_range(lat_max, lat_min);
      if (mem_q.size() != 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
      mem_q.push_back('{due: due, data: use_nop ? NOP_INST : $urandom});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    inflight.delete();
    mem_q.delete();
    m_pc = 32'h0;
    epoch = 0;
    m_fetched = 0;
    m_flushed = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef FETCH_STATS_EN
    chk({tag, "_stat_fetched"}, stat_fetched, 32'd0);
    chk({tag, "_stat_flushed"}, stat_flushed, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Steady stream with 1-cycle memory returning nops
    lat_min = 1; lat_max = 1; use_nop = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("first_latency", 32'(first_val_cyc - first_req_cyc), 32'd2);

    // Stall the consumer: requests stop once the FIFO is reserved full
    use_nop = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_req_valid", 32'(last_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // 3-cycle memory, redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && inflight.size() < 2; i++) tick();
    chk("two_outstanding", inflight.size(), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("redir_first_pc", inst_pc, 32'h0000_0100);
    for (int i = 0; i < 8; i++) tick();

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("rsp_in_redirect_cycle", 32'(mem_q.size() != 0 && mem_q[0].due <= cyc), 32'd1);
    chk("pop_in_redirect_cycle", 32'(inst_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    chk("redir_cycle_req_valid", 32'(last_req_valid), 32'd0);
    redirect = 1'b0;
    tick();
    chk("post_redir_req_valid", 32'(last_req_valid), 32'd1);
    chk("post_redir_req_addr", last_req_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) tick();

    // Halt with requests in flight: drain then resume
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && inflight.size() == 0; i++) tick();
    halt = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("halt_busy_drained", 32'(last_busy), 32'd0);
    chk("halt_req_valid", 32'(last_req_valid), 32'd0);
    halt = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Misaligned redirect near the top of memory, then address wrap
    lat_min = 1; lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_addr0", last_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", last_req_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      imem_req_ready = ($urandom_range(99, 0) < 80);
      inst_ready     = ($urandom_range(99, 0) < 70);
      redirect       = ($urandom_range(99, 0) < 6);
      redirect_pc    = $urandom;
      if ($urandom_range(99, 0) < 8) halt = ~halt;
      tick();
    end
    redirect = 1'b0;
    halt = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Asynchronous reset mid-operation
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/execute datapath.
- Issues in-order word fetches to instruction memory and buffers returned words with their PC in a small prefetch FIFO.
- Presents {pc, inst} to the datapath over a valid/ready handshake.
- Accepts PC redirects (taken branch, jal, jalr) and halt (ebreak) from the datapath; flushes wrong-path work on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded at reset.
- DEPTH_LOG2, 2, prefetch FIFO holds 2**DEPTH_LOG2 entries.
- MAX_OUTST, 2, maximum imem requests in flight (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address of request, bits[1:0]=00.
- imem_rsp_valid  in  1  response word valid; in order; cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  datapath consumes head.
- inst_pc  out  32  PC of head.
- inst_data  out  32  instruction of head.
- redirect  in  1  one-cycle pulse: flush and refetch.
- redirect_pc  in  32  new fetch PC; bits[1:0] ignored, forced to 00.
- halt  in  1  level: stop issuing requests.
- busy  out  1  outstanding != 0 or FIFO non-empty.

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; imem_req_valid=0; inst_valid=0; inst_pc=0; inst_data=0; busy=0.
- Request issue: imem_req_valid=1 when !halt && !redirect && (fifo_count + outstanding) < 2**DEPTH_LOG2 && outstanding < MAX_OUTST. The FIFO therefore never overflows.
- On accept (valid && ready): outstanding++; fetch_pc += 4, wrapping modulo 2**32.
- Request PC tracking: a tag FIFO of depth MAX_OUTST stores the PC of each in-flight request.
- Response handling:
  - If drop_cnt>0: drop_cnt--, outstanding--, word discarded.
  - Otherwise: push {tag PC, data} into the FIFO; outstanding--.
- Response latency: a pushed word is visible on inst_* the next cycle. Minimum issue-to-present latency is 2 cycles with a 1-cycle memory.
- Output: registered FIFO head. Pop on inst_valid && inst_ready. Push and pop in the same cycle are both allowed, including when full and when empty with one entry arriving.
- Redirect (highest priority):
  - FIFO cleared; inst_valid=0 the next cycle.
  - fetch_pc=redirect_pc&~3.
  - drop_cnt = outstanding after this cycle's response decrement.
  - imem_req_valid forced 0 in the redirect cycle.
  - A response arriving in the redirect cycle is discarded. A pop in the redirect cycle still completes.
  - First new request issues the cycle after the redirect.
- Redirect while drop_cnt>0: drop_cnt recomputed as above; never double-counts.
- Halt:
  - No new requests; in-flight responses still land; FIFO continues to drain.
  - Deasserting halt resumes from the current fetch_pc.
  - Redirect during halt updates fetch_pc and flushes as normal.
- busy=0 only when outstanding=0 and the FIFO is empty.
- Reset mid-operation: all state returns to reset values immediately. Memory responses in flight across a reset are the memory's responsibility to cancel.

Optional Feature:
- FETCH_STATS_EN defined:
  - Adds outputs stat_fetched[31:0] (instructions popped) and stat_flushed[31:0] (FIFO entries cleared plus responses dropped).
  - Both reset to 0, saturate at 32'hFFFF_FFFF.
  - A redirect adds fifo_count (after this cycle's pop) + 1 if a response is dropped that cycle.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package / defines:
  - fetch entry typedef {pc[31:0], inst[31:0]}.
  - constants INST_BYTES=4 and NOP_INST=32'h0000_0013.
- Sub-module fetch_fifo: parameterised synchronous FIFO with push/pop/clear, count, full/empty.
  - Instantiated twice: prefetch FIFO (width 64) and tag FIFO (width 32, depth MAX_OUTST).

Test Plan:
- Reset release, memory always ready, 1-cycle response returning 32'h0000_0013 → inst_pc=0,4,8,... with one instruction per cycle once steady; first inst_valid 2 cycles after first request.
- inst_ready=0 for 10 cycles → imem_req_valid drops once 4 entries are buffered; no response lost. Releasing ready → PCs 0,4,8,12 in order.
- Memory 3-cycle latency, 2 requests outstanding (PC 8, 12), redirect to 32'h100 → both responses dropped; next inst_pc=32'h100; stat_flushed counts FIFO entries + 2.
- Redirect in the same cycle as a response and a pop → popped entry consumed once; response discarded; imem_req_valid=0 that cycle; request 32'h100 issued next cycle.
- halt=1 with 1 outstanding → response still delivered; no further requests; busy falls after the drain. halt=0 → fetch resumes at the next sequential PC.
- redirect_pc=32'hFFFF_FFFE → fetch at 32'hFFFF_FFFC, then wraps to 32'h0000_0000.
